// File: rtl/sub_sequencer_if.sv
// Operand/result handshake bundle for sub_sequencer.
// The requester drives the master side and the block drives the slave side.
interface sub_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] o;
  logic             cout;
  logic             o_valid;
  logic             o_ready;
  logic             busy;

  modport master (
    output i0, i1, start_valid, o_ready,
    input  start_ready, o, cout, o_valid, busy
  );

  modport slave (
    input  i0, i1, start_valid, o_ready,
    output start_ready, o, cout, o_valid, busy
  );
endinterface

// File: rtl/sub_sequencer.sv
// Serial unsigned subtractor: it produces I0 - I1 two bits per cycle, LSB digit first.
// It computes A + ~B + 1 with a single 2-bit carry slice, and cout = 1 means no borrow.
module sub_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  sub_sequencer_if.slave  bus
);
  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] o_q;
  logic             cout_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       sum;
  logic [WIDTH-1:0] digit_placed;

  // The operands shift right each cycle, so the active digit is always bits [1:0].
  assign sum          = {1'b0, a_q[1:0]} + {1'b0, ~b_q[1:0]} + {2'b00, carry};
  assign digit_placed = WIDTH'(sum[1:0]) << {cnt, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      o_q    <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q   <= bus.i0;
            b_q   <= bus.i1;
            o_q   <= '0;
            carry <= 1'b1;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          o_q   <= o_q | digit_placed;
          carry <= sum[2];
          a_q   <= a_q >> 2;
          b_q   <= b_q >> 2;
          // The counter holds at the terminal count so it never wraps.
          if (cnt == LAST_CNT) begin
            cout_q <= sum[2];
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.o_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is masked by reset so that no requester sees it during reset.
  assign bus.start_ready = (state == IDLE) && !reset;
  assign bus.busy        = (state == RUN);
  assign bus.o_valid     = (state == DONE);
  assign bus.o           = o_q;
  assign bus.cout        = cout_q;
endmodule

// File: tb/tb_sub_sequencer.sv
// Directed bench for sub_sequencer: the main scenarios run at WIDTH=8, with operand sweeps at WIDTH=2 and WIDTH=16.
module tb_sub_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sub_sequencer_if #(.WIDTH(8))  bus8();
  sub_sequencer_if #(.WIDTH(2))  bus2();
  sub_sequencer_if #(.WIDTH(16)) bus16();

  sub_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  sub_sequencer #(.WIDTH(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));
  sub_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    bus8.i0 = a;
    bus8.i1 = b;
    bus8.start_valid = 1'b1;
    tick();
    bus8.start_valid = 1'b0;
    check("accept_busy", 64'(bus8.busy), 64'd1);
  endtask

  task automatic wait_done8(input string tag, input logic [7:0] exp_o, input logic exp_c);
    int n = 0;
    while (!bus8.o_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_o"}, 64'(bus8.o), 64'(exp_o));
    check({tag, "_cout"}, 64'(bus8.cout), 64'(exp_c));
  endtask

  task automatic finish8(input string tag, input logic [7:0] exp_o);
    bus8.o_ready = 1'b1;
    tick();
    bus8.o_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(bus8.start_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(bus8.o_valid), 64'd0);
    check({tag, "_retain"}, 64'(bus8.o), 64'(exp_o));
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] exp;
    int n = 0;
    exp = {1'b0, a} + {1'b0, ~b} + 3'd1;
    bus2.i0 = a;
    bus2.i1 = b;
    bus2.start_valid = 1'b1;
    tick();
    bus2.start_valid = 1'b0;
    while (!bus2.o_valid && n < 20) begin
      tick();
      n++;
    end
    check("w2_latency", 64'(n), 64'd1);
    check("w2_result", 64'({bus2.cout, bus2.o}), 64'(exp));
    bus2.o_ready = 1'b1;
    tick();
    bus2.o_ready = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] exp;
    int n = 0;
    exp = {1'b0, a} + {1'b0, ~b} + 17'd1;
    bus16.i0 = a;
    bus16.i1 = b;
    bus16.start_valid = 1'b1;
    tick();
    bus16.start_valid = 1'b0;
    while (!bus16.o_valid && n < 40) begin
      tick();
      n++;
    end
    check("w16_latency", 64'(n), 64'd8);
    check("w16_result", 64'({bus16.cout, bus16.o}), 64'(exp));
    bus16.o_ready = 1'b1;
    tick();
    bus16.o_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus8.i0 = '0;  bus8.i1 = '0;  bus8.start_valid = 1'b0;  bus8.o_ready = 1'b0;
    bus2.i0 = '0;  bus2.i1 = '0;  bus2.start_valid = 1'b0;  bus2.o_ready = 1'b0;
    bus16.i0 = '0; bus16.i1 = '0; bus16.start_valid = 1'b0; bus16.o_ready = 1'b0;
    repeat (2) tick();

    // Values while in reset
    check("rst_ready", 64'(bus8.start_ready), 64'd0);
    check("rst_o", 64'(bus8.o), 64'd0);
    check("rst_cout", 64'(bus8.cout), 64'd0);
    check("rst_valid", 64'(bus8.o_valid), 64'd0);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus8.start_ready), 64'd1);
    tick();

    // Basic differences
    start8(8'h35, 8'h12); wait_done8("d35_12", 8'h23, 1'b1); finish8("d35_12", 8'h23);
    start8(8'h00, 8'h01); wait_done8("d00_01", 8'hFF, 1'b0); finish8("d00_01", 8'hFF);
    start8(8'hA5, 8'hA5); wait_done8("dA5_A5", 8'h00, 1'b1); finish8("dA5_A5", 8'h00);
    start8(8'hFF, 8'h00); wait_done8("dFF_00", 8'hFF, 1'b1); finish8("dFF_00", 8'hFF);
    start8(8'h00, 8'hFF); wait_done8("d00_FF", 8'h01, 1'b0); finish8("d00_FF", 8'h01);

    // Backpressure: the result must hold while the consumer stalls
    start8(8'h80, 8'h01);
    wait_done8("bp", 8'h7F, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(bus8.o_valid), 64'd1);
      check("bp_hold", 64'({bus8.cout, bus8.o}), 64'h17F);
      check("bp_ready", 64'(bus8.start_ready), 64'd0);
    end
    finish8("bp", 8'h7F);

    // Start held high with changing operands during RUN and DONE
    bus8.i0 = 8'h9C;
    bus8.i1 = 8'h3B;
    bus8.start_valid = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus8.i0 = 8'($urandom);
      bus8.i1 = 8'($urandom);
      tick();
    end
    check("hold_valid", 64'(bus8.o_valid), 64'd1);
    check("hold_result", 64'({bus8.cout, bus8.o}), 64'h161);
    bus8.o_ready = 1'b1;
    tick();
    bus8.o_ready = 1'b0;
    check("hold_no_same_cycle_accept", 64'(bus8.busy), 64'd0);
    check("hold_idle_ready", 64'(bus8.start_ready), 64'd1);
    bus8.start_valid = 1'b0;
    tick();

    // Reset that aborts a running operation
    start8(8'h35, 8'h12);
    reset = 1'b1;
    tick();
    check("abort_o", 64'(bus8.o), 64'd0);
    check("abort_cout", 64'(bus8.cout), 64'd0);
    check("abort_valid", 64'(bus8.o_valid), 64'd0);
    check("abort_busy", 64'(bus8.busy), 64'd0);
    check("abort_ready_gated", 64'(bus8.start_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("abort_ready", 64'(bus8.start_ready), 64'd1);
    start8(8'h44, 8'h11); wait_done8("after_abort", 8'h33, 1'b1); finish8("after_abort", 8'h33);

    // Operand sweeps at the other widths
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        op2(2'(a), 2'(b));
    op16(16'h0000, 16'h0001);
    op16(16'hFFFF, 16'hFFFF);
    op16(16'h1234, 16'h0FED);
    for (int i = 0; i < 8; i++)
      op16(16'($urandom), 16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
